// File: rtl/fp_pkg.sv
// Shared float constants and the sequencer state type for the softmax datapath.
package fp_pkg;

  localparam int FP_W = 32;

  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

  typedef enum logic [2:0] {
    GET_X,
    SEND_A,
    SEND_B,
    GET_Z,
    PUT_SUM
  } seq_state_e;

endpackage

// File: rtl/stb_ack_sender.sv
// Registered strobe/data holder for one stb/ack send port.
// Data loads independently of the strobe so an operand can be staged early.
module stb_ack_sender
  import fp_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         start,
  input  logic         abort,
  input  logic         ack,
  output logic [W-1:0] data,
  output logic         stb
);

  logic [W-1:0] data_q, data_d;
  logic         stb_q, stb_d;

  always_comb begin
    data_d = data_q;
    stb_d  = stb_q;
    if (load) begin
      data_d = load_data;
    end
    // The transfer edge and an abort both win over a new start request.
    if (abort || (stb_q && ack)) begin
      stb_d = 1'b0;
    end else if (start) begin
      stb_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      stb_q  <= stb_d;
    end
  end

  assign data = data_q;
  assign stb  = stb_q;

endmodule

// File: rtl/fp_add_sequencer.sv
// Reduces frames of N floats to one sum through an external stb/ack adder.
// Optional adder watchdog with sticky err output: define ADDSEQ_TIMEOUT_EN.
module fp_add_sequencer
  import fp_pkg::*;
#(
  parameter int N     = 10,
  parameter int CNT_W = 8
`ifdef ADDSEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [FP_W-1:0] in_data,
  input  logic            in_stb,
  output logic            in_ack,
  output logic [FP_W-1:0] add_a,
  output logic            add_a_stb,
  input  logic            add_a_ack,
  output logic [FP_W-1:0] add_b,
  output logic            add_b_stb,
  input  logic            add_b_ack,
  input  logic [FP_W-1:0] add_z,
  input  logic            add_z_stb,
  output logic            add_z_ack,
  output logic [FP_W-1:0] out_z,
  output logic            out_stb,
  input  logic            out_ack
`ifdef ADDSEQ_TIMEOUT_EN
  ,
  output logic            err
`endif
);

  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [FP_W-1:0]  acc_q, acc_d;
  logic             in_ack_q, in_ack_d;
  logic             z_ack_q, z_ack_d;

  logic in_xfer, a_xfer, b_xfer, z_xfer, o_xfer;
  logic a_load, a_start, b_load, b_start, o_load, o_start;
  logic adder_abort;

`ifdef ADDSEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             waiting;
  logic             adder_xfer;
`endif

  assign in_xfer = in_stb && in_ack_q;
  assign a_xfer  = add_a_stb && add_a_ack;
  assign b_xfer  = add_b_stb && add_b_ack;
  assign z_xfer  = add_z_stb && z_ack_q;
  assign o_xfer  = out_stb && out_ack;
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    in_ack_d    = 1'b0;
    z_ack_d     = 1'b0;
    a_load      = 1'b0;
    a_start     = 1'b0;
    b_load      = 1'b0;
    b_start     = 1'b0;
    o_load      = 1'b0;
    o_start     = 1'b0;
    adder_abort = 1'b0;
`ifdef ADDSEQ_TIMEOUT_EN
    err_d       = err_q;
    tmo_d       = '0;
    waiting     = 1'b0;
    adder_xfer  = 1'b0;
`endif

    case (state_q)
      GET_X: begin
        in_ack_d = 1'b1;
        if (in_xfer) begin
          in_ack_d = 1'b0;
          if (cnt_q == '0) begin
            // First element of a frame seeds the accumulator without an add.
            acc_d = in_data;
            cnt_d = CNT_W'(1);
            if (N == 1) begin
              state_d = PUT_SUM;
            end
          end else begin
            a_load  = 1'b1;
            a_start = 1'b1;
            b_load  = 1'b1;
            state_d = SEND_A;
          end
        end
      end
      SEND_A: begin
        if (a_xfer) begin
          b_start = 1'b1;
          state_d = SEND_B;
        end
      end
      SEND_B: begin
        if (b_xfer) begin
          state_d = GET_Z;
        end
      end
      GET_Z: begin
        z_ack_d = 1'b1;
        if (z_xfer) begin
          z_ack_d = 1'b0;
          acc_d   = add_z;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == N_CNT) ? PUT_SUM : GET_X;
        end
      end
      PUT_SUM: begin
        o_load  = !out_stb;
        o_start = !out_stb;
        if (o_xfer) begin
          cnt_d   = '0;
          state_d = GET_X;
        end
      end
      default: begin
        state_d = GET_X;
      end
    endcase

`ifdef ADDSEQ_TIMEOUT_EN
    waiting    = (state_q == SEND_A) || (state_q == SEND_B) || (state_q == GET_Z);
    adder_xfer = a_xfer || b_xfer || z_xfer;
    if (waiting && !adder_xfer) begin
      tmo_d = tmo_q + TMO_W'(1);
      // A stuck adder abandons the frame; the partial sum is meaningless.
      if (tmo_q == TMO_LAST) begin
        tmo_d       = '0;
        err_d       = 1'b1;
        adder_abort = 1'b1;
        z_ack_d     = 1'b0;
        b_start     = 1'b0;
        cnt_d       = '0;
        state_d     = GET_X;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= GET_X;
      cnt_q    <= '0;
      acc_q    <= FP_ZERO;
      in_ack_q <= 1'b0;
      z_ack_q  <= 1'b0;
`ifdef ADDSEQ_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      in_ack_q <= in_ack_d;
      z_ack_q  <= z_ack_d;
`ifdef ADDSEQ_TIMEOUT_EN
      tmo_q    <= tmo_d;
      err_q    <= err_d;
`endif
    end
  end

  stb_ack_sender #(.W(FP_W)) u_send_a (
    .clk       (clk),
    .rst       (rst),
    .load      (a_load),
    .load_data (acc_q),
    .start     (a_start),
    .abort     (adder_abort),
    .ack       (add_a_ack),
    .data      (add_a),
    .stb       (add_a_stb)
  );

  stb_ack_sender #(.W(FP_W)) u_send_b (
    .clk       (clk),
    .rst       (rst),
    .load      (b_load),
    .load_data (in_data),
    .start     (b_start),
    .abort     (adder_abort),
    .ack       (add_b_ack),
    .data      (add_b),
    .stb       (add_b_stb)
  );

  stb_ack_sender #(.W(FP_W)) u_send_out (
    .clk       (clk),
    .rst       (rst),
    .load      (o_load),
    .load_data (acc_q),
    .start     (o_start),
    .abort     (1'b0),
    .ack       (out_ack),
    .data      (out_z),
    .stb       (out_stb)
  );

  assign in_ack    = in_ack_q;
  assign add_z_ack = z_ack_q;

`ifdef ADDSEQ_TIMEOUT_EN
  assign err = err_q;
`endif

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
Initiator-side controller for the team's stb/ack single-precision adder. It accepts a stream of N IEEE-754 floats from an upstream producer and reduces them to one running sum by driving an external adder's a/b/z ports. It then presents the sum downstream. It sits between the exponent stage and the normaliser of the softmax datapath, where it forms the denominator sum.

Parameters:
N, 10, number of floats summed per frame (N >= 1)
CNT_W, 8, element counter width; must satisfy 2**CNT_W > N

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
in_data  in  32  upstream float element
in_stb  in  1  upstream data valid
in_ack  out  1  this block ready to accept in_data
add_a  out  32  operand a to adder (running accumulator)
add_a_stb  out  1  operand a valid
add_a_ack  in  1  adder accepts a
add_b  out  32  operand b to adder (new element)
add_b_stb  out  1  operand b valid
add_b_ack  in  1  adder accepts b
add_z  in  32  adder result
add_z_stb  in  1  adder result valid
add_z_ack  out  1  this block accepts add_z
out_z  out  32  final sum of N elements
out_stb  out  1  final sum valid
out_ack  in  1  downstream accepts out_z

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-low. While rst=0: state=GET_X; in_ack, add_a_stb, add_b_stb, add_z_ack and out_stb are 0; add_a, add_b and out_z are 0; acc=0; cnt=0.
- Handshake, all interfaces: a transfer occurs on a rising edge where stb and ack are both 1.
  - Acks are registered. Each ack rises one cycle after entering its wait state and clears on the transfer edge.
  - Strobes driven by this block are registered. Their data is stable while the strobe is high, and the strobe clears on the transfer edge.
  - There is no combinational path from any input to any output.
- GET_X: set in_ack=1; on transfer, capture in_data into x.
  - cnt==0: acc<=x, cnt<=1. If N==1 go to PUT_SUM, else stay in GET_X.
  - cnt>0: add_a<=acc, add_b<=x, go to SEND_A.
- SEND_A: add_a_stb=1 until add_a transfer, then go to SEND_B. add_b is already loaded.
- SEND_B: add_b_stb=1 until add_b transfer, then go to GET_Z. This order is fixed to match the adder, which takes a before b.
- GET_Z: add_z_ack=1; on transfer, acc<=add_z, cnt<=cnt+1.
  - If cnt+1==N go to PUT_SUM, else go to GET_X.
- PUT_SUM: out_z<=acc, out_stb=1 until out transfer. Then cnt<=0 and go to GET_X.
- Latency: per element, roughly 2 handshake cycles plus adder latency. The first element of a frame costs one handshake and no adder pass.
- Backpressure: in_ack stays 0 outside GET_X, so upstream stalls while an add is in flight or the sum is unaccepted. out_ack held low holds out_stb and out_z indefinitely.
- Data: the block never inspects or modifies float contents. NaN, inf and denormals pass through the adder unchanged; rounding belongs to the adder.
- Counter: cnt never exceeds N and wraps to 0 only on the PUT_SUM transfer.
- Reset mid-frame: the partial sum is discarded and all strobes and acks drop asynchronously. The external adder must be reset in the same domain; no resynchronisation is attempted.

Optional Feature:
ADDSEQ_TIMEOUT_EN
- Defined:
  - Adds output port err (1 bit, reset 0) and parameter TIMEOUT (default 255).
  - A counter runs while in SEND_A, SEND_B or GET_Z and clears on each adder transfer.
  - If it reaches TIMEOUT: err<=1 (sticky until reset), all adder strobes and acks drop, cnt<=0, go to GET_X.
- Undefined: no err port and no counter; the block waits on the adder forever.

Decomposition:
- Shared package fp_pkg:
  - float width constant FP_W=32
  - state enum for this block: GET_X, SEND_A, SEND_B, GET_Z, PUT_SUM
  - constants FP_ZERO=32'h0 and FP_ONE=32'h3F800000 for benches
- One natural sub-module: stb_ack_sender. It is the registered strobe/data holder and is instantiated for add_a, add_b and out_z. The receive side stays inline.

Test Plan:
1. N=3, connected to the team adder, inputs 3F800000, 40000000, 40400000 -> out_z=40C00000 (6.0), out_stb held until out_ack.
2. N=1, input C1200000 -> out_z=C1200000 with no add_a_stb ever asserted.
3. N=3, out_ack held 0 for 20 cycles -> out_stb and out_z stable; in_ack stays 0 with in_stb high; the next frame starts only after the ack.
4. Behavioural adder with add_a_ack delayed 7 cycles -> add_a_stb and add_a stay stable for the whole delay; add_b_stb does not assert before the a transfer.
5. rst pulsed low during GET_Z of a 4-element frame -> all strobes and acks are 0 immediately; a new frame 3F800000 x4 after reset gives 40800000.
6. With ADDSEQ_TIMEOUT_EN and TIMEOUT=16, adder never acks -> err=1 at cycle 16 of SEND_A, state returns to GET_X, in_ack rises.
